// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: register file, main control decode, sign extension, branch/jump
// resolution and hazard detection, registered into the ID/EX pipeline register.
module instruction_decode_stage #(
    parameter int PC_W   = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   PC_plus_4,
    input  logic [31:0]       instruction,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [4:0]        mem_write_reg,
    input  logic [DATA_W-1:0] mem_alu_result,
    output logic              stall,
    output logic              IF_Flush,
    output logic              pc_redirect,
    output logic [PC_W-1:0]   redirect_target,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic [1:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_read_data1,
    output logic [DATA_W-1:0] ex_read_data2,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [PC_W-1:0]   ex_PC_plus_4
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] imm_ext;

    assign opcode  = instruction[31:26];
    assign rs      = instruction[25:21];
    assign rt      = instruction[20:16];
    assign rd      = instruction[15:11];
    assign imm_ext = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] rf_rs, rf_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wb_reg_write && wb_write_reg != 5'd0) begin
            regs_q[wb_write_reg] <= wb_write_data;
        end
    end

    // WB bypass lets a value written this cycle be seen without waiting for the edge
    always_comb begin
        rf_rs = regs_q[rs];
        rf_rt = regs_q[rt];
        if (wb_reg_write && wb_write_reg == rs) rf_rs = wb_write_data;
        if (wb_reg_write && wb_write_reg == rt) rf_rt = wb_write_data;
        if (rs == 5'd0) rf_rs = '0;
        if (rt == 5'd0) rf_rt = '0;
    end

    logic       ctl_reg_write, ctl_mem_to_reg, ctl_mem_read, ctl_mem_write;
    logic       ctl_alu_src, ctl_reg_dst;
    logic [1:0] ctl_alu_op;
    logic       is_beq, is_bne, is_j, is_branch;

    always_comb begin
        ctl_reg_write  = 1'b0;
        ctl_mem_to_reg = 1'b0;
        ctl_mem_read   = 1'b0;
        ctl_mem_write  = 1'b0;
        ctl_alu_src    = 1'b0;
        ctl_reg_dst    = 1'b0;
        ctl_alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                ctl_reg_write = 1'b1;
                ctl_reg_dst   = 1'b1;
                ctl_alu_op    = 2'b10;
            end
            OP_LW: begin
                ctl_reg_write  = 1'b1;
                ctl_mem_read   = 1'b1;
                ctl_mem_to_reg = 1'b1;
                ctl_alu_src    = 1'b1;
            end
            OP_SW: begin
                ctl_mem_write = 1'b1;
                ctl_alu_src   = 1'b1;
            end
            OP_ADDI: begin
                ctl_reg_write = 1'b1;
                ctl_alu_src   = 1'b1;
            end
            OP_BEQ, OP_BNE: ctl_alu_op = 2'b01;
            default: ;
        endcase
    end

    assign is_beq    = (opcode == OP_BEQ);
    assign is_bne    = (opcode == OP_BNE);
    assign is_j      = (opcode == OP_J);
    assign is_branch = is_beq | is_bne;

    logic [4:0] ex_dest;
    logic       haz_load_use, haz_br_ex, haz_br_mem, stall_raw;

    assign ex_dest      = ex_reg_dst ? ex_rd : ex_rt;
    assign haz_load_use = ex_mem_read && ex_rt != 5'd0 && (ex_rt == rs || ex_rt == rt);
    assign haz_br_ex    = is_branch && ex_reg_write && ex_dest != 5'd0
                          && (ex_dest == rs || ex_dest == rt);
    assign haz_br_mem   = is_branch && mem_mem_read && mem_write_reg != 5'd0
                          && (mem_write_reg == rs || mem_write_reg == rt);
    assign stall_raw    = haz_load_use | haz_br_ex | haz_br_mem;

    logic              fwd_ok;
    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              taken;
    logic [PC_W-1:0]   branch_target, jump_target;

    assign fwd_ok = mem_reg_write && !mem_mem_read && mem_write_reg != 5'd0;
    assign cmp_a  = (fwd_ok && mem_write_reg == rs) ? mem_alu_result : rf_rs;
    assign cmp_b  = (fwd_ok && mem_write_reg == rt) ? mem_alu_result : rf_rt;
    assign taken  = (is_beq && cmp_a == cmp_b) || (is_bne && cmp_a != cmp_b) || is_j;

    // Offset truncated to PC width so the sum wraps modulo 2^PC_W
    assign branch_target = PC_plus_4 + {imm_ext[PC_W-3:0], 2'b00};
    assign jump_target   = {instruction[PC_W-3:0], 2'b00};

    assign stall           = rst_n && stall_raw;
    assign pc_redirect     = rst_n && !stall_raw && taken;
    assign IF_Flush        = pc_redirect;
    assign redirect_target = pc_redirect ? (is_j ? jump_target : branch_target) : '0;

    logic              reg_write_d, mem_to_reg_d, mem_read_d, mem_write_d, alu_src_d, reg_dst_d;
    logic [1:0]        alu_op_d;
    logic [DATA_W-1:0] read_data1_d, read_data2_d, imm_ext_d;
    logic [4:0]        rs_d, rt_d, rd_d;
    logic [PC_W-1:0]   pc_plus_4_d;

    always_comb begin
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        reg_dst_d    = 1'b0;
        alu_op_d     = 2'b00;
        read_data1_d = '0;
        read_data2_d = '0;
        imm_ext_d    = '0;
        rs_d         = '0;
        rt_d         = '0;
        rd_d         = '0;
        pc_plus_4_d  = '0;
        if (!stall_raw) begin
            reg_write_d  = ctl_reg_write;
            mem_to_reg_d = ctl_mem_to_reg;
            mem_read_d   = ctl_mem_read;
            mem_write_d  = ctl_mem_write;
            alu_src_d    = ctl_alu_src;
            reg_dst_d    = ctl_reg_dst;
            alu_op_d     = ctl_alu_op;
            read_data1_d = rf_rs;
            read_data2_d = rf_rt;
            imm_ext_d    = imm_ext;
            rs_d         = rs;
            rt_d         = rt;
            rd_d         = rd;
            pc_plus_4_d  = PC_plus_4;
        end
    end

    logic              reg_write_q, mem_to_reg_q, mem_read_q, mem_write_q, alu_src_q, reg_dst_q;
    logic [1:0]        alu_op_q;
    logic [DATA_W-1:0] read_data1_q, read_data2_q, imm_ext_q;
    logic [4:0]        rs_q, rt_q, rd_q;
    logic [PC_W-1:0]   pc_plus_4_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            alu_op_q     <= 2'b00;
            read_data1_q <= '0;
            read_data2_q <= '0;
            imm_ext_q    <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            pc_plus_4_q  <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            reg_dst_q    <= reg_dst_d;
            alu_op_q     <= alu_op_d;
            read_data1_q <= read_data1_d;
            read_data2_q <= read_data2_d;
            imm_ext_q    <= imm_ext_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            pc_plus_4_q  <= pc_plus_4_d;
        end
    end

    assign ex_reg_write  = reg_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_alu_src    = alu_src_q;
    assign ex_reg_dst    = reg_dst_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_read_data1 = read_data1_q;
    assign ex_read_data2 = read_data2_q;
    assign ex_imm_ext    = imm_ext_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;
    assign ex_PC_plus_4  = pc_plus_4_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: directed scenarios plus random traffic,
// checked by a queue-based scoreboard fed from a behavioural reference model.
module tb_instruction_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  PC_plus_4;
    logic [31:0] instruction;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        mem_reg_write, mem_mem_read;
    logic [4:0]  mem_write_reg;
    logic [31:0] mem_alu_result;
    logic        stall, IF_Flush, pc_redirect;
    logic [5:0]  redirect_target;
    logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_read_data1, ex_read_data2, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_PC_plus_4;

    instruction_decode_stage #(.PC_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .PC_plus_4(PC_plus_4), .instruction(instruction),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_write_reg(mem_write_reg), .mem_alu_result(mem_alu_result),
        .stall(stall), .IF_Flush(IF_Flush), .pc_redirect(pc_redirect),
        .redirect_target(redirect_target),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .ex_alu_op(ex_alu_op), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
        .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_PC_plus_4(ex_PC_plus_4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mtr, mr, mw, as, rdst;
        logic [1:0]  aop;
        logic [31:0] d1, d2, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  pc;
    } ex_t;

    typedef struct packed {
        logic       st, fl, rdr;
        logic [5:0] tgt;
        ex_t        ex;
    } rec_t;

    rec_t        sb_q[$];
    ex_t         m_ex;
    logic [31:0] m_regs [32];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ex = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    // Control table: {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_op}
    function automatic logic [7:0] ctl_of(input logic [5:0] op);
        case (op)
            6'h00:        return 8'b100001_10;
            6'h23:        return 8'b111010_00;
            6'h2B:        return 8'b000110_00;
            6'h08:        return 8'b100010_00;
            6'h04, 6'h05: return 8'b000000_01;
            default:      return 8'b000000_00;
        endcase
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_reg_write && wb_write_reg == r) return wb_write_data;
        return m_regs[r];
    endfunction

    function automatic logic touches(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b);
        return (r != 0) && (r == a || r == b);
    endfunction

    // One ID cycle of the reference model, driven from the current DUT inputs
    task automatic model_step(output rec_t rec);
        logic [5:0]  op;
        logic [4:0]  rs, rt, dest;
        logic [31:0] a, b, imm;
        logic        br, fwd, taken;
        logic [7:0]  c;
        int          t;
        op  = instruction[31:26];
        rs  = instruction[25:21];
        rt  = instruction[20:16];
        imm = {{16{instruction[15]}}, instruction[15:0]};
        br  = (op == 6'h04) || (op == 6'h05);
        dest = m_ex.rdst ? m_ex.rd : m_ex.rt;
        rec = '0;
        rec.st = (m_ex.mr && touches(m_ex.rt, rs, rt))
               || (br && m_ex.rw && touches(dest, rs, rt))
               || (br && mem_mem_read && touches(mem_write_reg, rs, rt));
        fwd = mem_reg_write && !mem_mem_read && mem_write_reg != 0;
        a = (fwd && mem_write_reg == rs) ? mem_alu_result : rf_read(rs);
        b = (fwd && mem_write_reg == rt) ? mem_alu_result : rf_read(rt);
        taken = (op == 6'h04 && a == b) || (op == 6'h05 && a != b) || (op == 6'h02);
        rec.rdr = !rec.st && taken;
        rec.fl  = rec.rdr;
        if (op == 6'h02) t = int'(instruction[3:0]) * 4;
        else             t = int'(PC_plus_4) + 4 * int'($signed(instruction[15:0]));
        t = t & 63;
        if (rec.rdr) rec.tgt = t[5:0];
        if (!rec.st) begin
            c = ctl_of(op);
            {rec.ex.rw, rec.ex.mtr, rec.ex.mr, rec.ex.mw, rec.ex.as, rec.ex.rdst, rec.ex.aop} = c;
            rec.ex.d1  = rf_read(rs);
            rec.ex.d2  = rf_read(rt);
            rec.ex.imm = imm;
            rec.ex.rs  = rs;
            rec.ex.rt  = rt;
            rec.ex.rd  = instruction[15:11];
            rec.ex.pc  = PC_plus_4;
        end
        m_ex = rec.ex;
        if (wb_reg_write && wb_write_reg != 0) m_regs[wb_write_reg] = wb_write_data;
    endtask

    task automatic drv(input logic [31:0] ins, input logic [5:0] pc,
                       input logic wwe, input logic [4:0] wreg, input logic [31:0] wdat,
                       input logic mrw, input logic mmr, input logic [4:0] mreg,
                       input logic [31:0] malu);
        rec_t r;
        @(posedge clk);
        #1;
        instruction    = ins;
        PC_plus_4      = pc;
        wb_reg_write   = wwe;
        wb_write_reg   = wreg;
        wb_write_data  = wdat;
        mem_reg_write  = mrw;
        mem_mem_read   = mmr;
        mem_write_reg  = mreg;
        mem_alu_result = malu;
        model_step(r);
        sb_q.push_back(r);
    endtask

    // Monitor: combinational outputs checked in their own cycle, ID/EX one edge later
    rec_t mon_prev;
    logic mon_prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_v = 1'b0;
        end else begin
            if (mon_prev_v) begin
                chk("ex_reg_write", ex_reg_write, mon_prev.ex.rw);
                chk("ex_mem_to_reg", ex_mem_to_reg, mon_prev.ex.mtr);
                chk("ex_mem_read", ex_mem_read, mon_prev.ex.mr);
                chk("ex_mem_write", ex_mem_write, mon_prev.ex.mw);
                chk("ex_alu_src", ex_alu_src, mon_prev.ex.as);
                chk("ex_reg_dst", ex_reg_dst, mon_prev.ex.rdst);
                chk("ex_alu_op", ex_alu_op, mon_prev.ex.aop);
                chk("ex_read_data1", ex_read_data1, mon_prev.ex.d1);
                chk("ex_read_data2", ex_read_data2, mon_prev.ex.d2);
                chk("ex_imm_ext", ex_imm_ext, mon_prev.ex.imm);
                chk("ex_rs", ex_rs, mon_prev.ex.rs);
                chk("ex_rt", ex_rt, mon_prev.ex.rt);
                chk("ex_rd", ex_rd, mon_prev.ex.rd);
                chk("ex_PC_plus_4", ex_PC_plus_4, mon_prev.ex.pc);
                mon_prev_v = 1'b0;
            end
            if (sb_q.size() > 0) begin
                mon_prev = sb_q.pop_front();
                chk("stall", stall, mon_prev.st);
                chk("IF_Flush", IF_Flush, mon_prev.fl);
                chk("pc_redirect", pc_redirect, mon_prev.rdr);
                chk("redirect_target", redirect_target, mon_prev.tgt);
                mon_prev_v = 1'b1;
            end
        end
    end

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'd2;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op;
        logic [31:0] ins;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h0F};

        rst_n = 1'b0;
        instruction = 32'd0; PC_plus_4 = 6'd0;
        wb_reg_write = 1'b0; wb_write_reg = 5'd0; wb_write_data = 32'd0;
        mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_write_reg = 5'd0; mem_alu_result = 32'd0;
        model_reset();
        #12;
        chk("reset ex_reg_write", ex_reg_write, 1'b0);
        chk("reset stall", stall, 1'b0);
        #10 rst_n = 1'b1;

        // WB bypass into add $6,$5,$6
        drv(32'h00A63020, 6'd8, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0);
        drv(32'h00003020, 6'd12, 1'b1, 5'd0, 32'h00001234, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("bypass ex_read_data1", ex_read_data1, 32'hDEADBEEF);
        chk("bypass ex_reg_dst", ex_reg_dst, 1'b1);
        chk("bypass ex_alu_op", ex_alu_op, 2'b10);
        drv(32'h00003020, 6'd16, 1'b1, 5'd1, 32'h00000011, 1'b0, 1'b0, 5'd0, 32'd0);
        #1 chk("r0 bypass read", ex_read_data1, 32'd0);
        // Load-use: lw $2,4($1) then add $3,$2,$4
        drv(32'h8C220004, 6'd20, 1'b1, 5'd4, 32'h00000044, 1'b0, 1'b0, 5'd0, 32'd0);
        #1 chk("r0 read after write", ex_read_data1, 32'd0);
        drv(32'h00441820, 6'd24, 1'b1, 5'd7, 32'h00000077, 1'b0, 1'b0, 5'd0, 32'd0);
        #1 chk("load-use stall", stall, 1'b1);
        drv(32'h00441820, 6'd24, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("load-use retry stall", stall, 1'b0);
        chk("load-use bubble", ex_reg_write, 1'b0);
        // beq $1,$1,+2 at PC+4=60 wraps to 4
        drv(32'h10210002, 6'd60, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("retry add ex_reg_write", ex_reg_write, 1'b1);
        chk("beq pc_redirect", pc_redirect, 1'b1);
        chk("beq IF_Flush", IF_Flush, 1'b1);
        chk("beq wrap target", redirect_target, 6'd4);
        drv(32'h14210002, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("bne pc_redirect", pc_redirect, 1'b0);
        chk("bne IF_Flush", IF_Flush, 1'b0);
        chk("beq ex_reg_write", ex_reg_write, 1'b0);
        // beq $7,$0: load in MEM stalls, then ALU result 0 forwarded
        drv(32'h10E00001, 6'd10, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'h00000099);
        #1;
        chk("mem load stall", stall, 1'b1);
        chk("mem load no redirect", pc_redirect, 1'b0);
        drv(32'h10E00001, 6'd10, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd7, 32'd0);
        #1;
        chk("mem fwd stall", stall, 1'b0);
        chk("mem fwd redirect", pc_redirect, 1'b1);
        chk("mem fwd target", redirect_target, 6'd14);
        drv(32'h08000005, 6'd30, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("j target", redirect_target, 6'd20);
        chk("j IF_Flush", IF_Flush, 1'b1);
        drv(32'h00003020, 6'd32, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("j ex_reg_write", ex_reg_write, 1'b0);
        chk("j ex_mem_write", ex_mem_write, 1'b0);
        chk("j ex_mem_read", ex_mem_read, 1'b0);

        // Mid-run asynchronous reset with a writing instruction in ID/EX
        @(posedge clk);
        #1;
        chk("pre-reset ex_reg_write", ex_reg_write, 1'b1);
        wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'h0BAD0BAD;
        rst_n = 1'b0;
        #1;
        chk("async ex_reg_write", ex_reg_write, 1'b0);
        chk("async ex_reg_dst", ex_reg_dst, 1'b0);
        chk("async ex_alu_op", ex_alu_op, 2'b00);
        chk("async ex_PC_plus_4", ex_PC_plus_4, 6'd0);
        chk("async stall", stall, 1'b0);
        chk("async IF_Flush", IF_Flush, 1'b0);
        chk("async pc_redirect", pc_redirect, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        wb_reg_write = 1'b0;
        rst_n = 1'b1;
        drv(32'h00A63020, 6'd8, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        drv(32'h00000000, 6'd12, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1 chk("post-reset $5", ex_read_data1, 32'd0);

        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 7)];
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 11'($urandom)};
            if ($urandom_range(0, 15) == 0) ins = 32'd0;
            drv(ins, 6'($urandom),
                1'($urandom), 5'($urandom_range(0, 7)), pick_data(),
                1'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), pick_data());
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
- ID stage of the five-stage MIPS pipeline. It sits directly downstream of the fetch stage and consumes its registered instruction (32 bit) and PC_plus_4 (6 bit).
- Contains the 32x32 register file, main control decode, sign extension, branch/jump resolution in ID, and load-use / branch-operand hazard detection.
- Registers results into the ID/EX pipeline register, drives IF_Flush back to fetch, and drives a stall to the PC/IF stages.

Parameters:
- PC_W, 6, program-counter width. Matches the fetch stage.
- DATA_W, 32, register and datapath width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- PC_plus_4  in  PC_W  from fetch stage.
- instruction  in  32  from fetch stage; 0 = NOP.
- wb_reg_write  in  1  writeback enable.
- wb_write_reg  in  5  writeback destination.
- wb_write_data  in  DATA_W  writeback data.
- mem_reg_write  in  1  EX/MEM writes a register.
- mem_mem_read  in  1  EX/MEM is a load.
- mem_write_reg  in  5  EX/MEM destination.
- mem_alu_result  in  DATA_W  EX/MEM ALU result, forwarded to branch compare.
- stall  out  1  high = upstream holds PC and fetch register this cycle.
- IF_Flush  out  1  high = fetch stage zeroes its instruction.
- pc_redirect  out  1  high = next PC is redirect_target.
- redirect_target  out  PC_W  branch or jump target.
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst  out  1 each  registered control.
- ex_alu_op  out  2  registered: 00 add, 01 sub, 10 funct.
- ex_read_data1, ex_read_data2, ex_imm_ext  out  DATA_W  registered operands.
- ex_rs, ex_rt, ex_rd  out  5 each  registered register fields.
- ex_PC_plus_4  out  PC_W  registered.

Behaviour:
- Reset (rst_n low, async):
  - All ex_* outputs go to 0 and all 32 registers clear to 0.
  - stall, IF_Flush and pc_redirect are forced to 0 while reset is held.
  - Writeback writes are ignored during reset.
- Decode, by opcode = instruction[31:26]:
  - 0x00 R-type: reg_write, reg_dst, alu_op=10.
  - 0x23 lw: reg_write, mem_read, mem_to_reg, alu_src, alu_op=00.
  - 0x2B sw: mem_write, alu_src, alu_op=00.
  - 0x08 addi: reg_write, alu_src, alu_op=00.
  - 0x04 beq / 0x05 bne: alu_op=01, all other controls 0.
  - 0x02 j: all controls 0.
  - Any other opcode: all controls 0 (bubble).
- Sign extension: imm_ext = {16{instr[15]}, instr[15:0]}.
- Register file:
  - Write on posedge when wb_reg_write and wb_write_reg != 0. Register $0 always reads 0.
  - Reads are combinational, with same-cycle WB bypass: if the WB destination matches rs/rt and is nonzero, the read returns wb_write_data.
- Hazards (combinational; stall = OR of the following):
  - Load-use: ex_mem_read and ex_rt != 0 and ex_rt matches rs or rt.
  - Branch (beq/bne) operand still in EX: ex_reg_write and the ID/EX destination (ex_reg_dst ? ex_rd : ex_rt) != 0 and matches rs or rt.
  - Branch operand is a load in MEM: mem_mem_read and mem_write_reg != 0 and matches rs or rt.
- Branch compare operands:
  - Use mem_alu_result when mem_reg_write, !mem_mem_read, and mem_write_reg (nonzero) matches.
  - Otherwise use the register-file read.
- Stall effects: the ID/EX register loads a bubble (all controls and all data 0). pc_redirect and IF_Flush are 0 that cycle.
- Redirect (only when not stalling):
  - beq with equal operands, or bne with unequal operands: target = (PC_plus_4 + (imm_ext << 2)) mod 2^PC_W. Wrap-around is required.
  - j: target = {instr[3:0], 2'b00}.
  - On redirect, pc_redirect=1 and IF_Flush=1 in the same cycle.
  - The branch or jump itself still enters ID/EX with reg_write and mem_write at 0.
  - Not taken: pc_redirect=0, redirect_target=0.
- Latency: one cycle from instruction to ex_*. Redirect and stall are combinational in the ID cycle.
- A WB write to the same register a stalled instruction reads is visible on the retry cycle.

Test Plan:
- Reset: hold rst_n low mid-run with ex_reg_write=1 -> all ex_* = 0 immediately, no clock needed. After release, reading $5 returns 0.
- WB bypass and $0:
  - WB writes $5=0xDEADBEEF while instruction=0x00A63020 (add $6,$5,$6) -> next edge ex_read_data1=0xDEADBEEF, ex_reg_dst=1, ex_alu_op=10.
  - WB write to $0 -> later reads of $0 = 0.
- Load-use: lw $2,4($1) then add $3,$2,$4 -> add cycle stall=1, ID/EX gets bubble. Next cycle add is decoded normally, stall=0.
- Branch taken with wrap: PC_plus_4=60, beq $1,$1,+2 (imm=0x0002) -> pc_redirect=1, IF_Flush=1, redirect_target=4.
- bne not taken: equal operands -> pc_redirect=0, IF_Flush=0.
- Branch operand from EX/MEM:
  - Load in MEM writes $7, then beq $7,$0 -> one stall cycle.
  - Non-load in MEM with mem_alu_result=0 -> no stall; branch taken using the forwarded 0.
- Jump: instruction 0x08000005 -> redirect_target=20, IF_Flush=1, ex_* controls 0.
